// File: rtl/bist_pattern_harness.sv
// LFSR-driven stimulus and MISR response compaction around a combinational benchmark.
// One run applies n_patterns vectors, waits out the DUT latency, then compares the signature.
module bist_pattern_harness #(
    parameter int                N_IN     = 11,
    parameter int                N_OUT    = 23,
    parameter logic [N_IN-1:0]   LFSR_TAP = 11'h500,
    parameter logic [N_OUT-1:0]  MISR_TAP = 23'h420000,
    parameter int                DUT_LAT  = 0,
    parameter int                CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_IN-1:0]  seed,
    input  logic [CNT_W-1:0] n_patterns,
    input  logic [N_OUT-1:0] golden,
    output logic [N_IN-1:0]  pat_out,
    output logic             pat_valid,
    input  logic [N_OUT-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] signature,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [N_IN-1:0]    r_lfsr;
    logic [N_OUT-1:0]   r_misr;
    logic [CNT_W-1:0]   r_count;
    logic [DW-1:0]      r_drain;
    logic               w_load;
    logic               w_last;
    logic               w_cap_en;
    logic               w_lfsr_fb;
    logic               w_misr_fb;

    assign w_load    = start && !abort && (r_state == IDLE || r_state == DONE);
    assign w_last    = (r_count == CNT_W'(1));
    assign w_lfsr_fb = ^(r_lfsr & LFSR_TAP);
    assign w_misr_fb = ^(r_misr & MISR_TAP);

    assign pat_out   = r_lfsr;
    assign pat_valid = (r_state == RUN);
    assign busy      = (r_state == RUN) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign signature = r_misr;
    assign pass      = (r_state == DONE) && (r_misr == golden);

    // Delay pat_valid by the DUT latency to know when resp_in belongs to a vector
    generate
        if (DUT_LAT == 0) begin : g_nodly
            assign w_cap_en = pat_valid;
        end else begin : g_dly
            logic [DUT_LAT-1:0] r_dly;
            // Valid delay line; flushed on abort so in-flight captures are dropped
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= '0;
                end else if (abort) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= (r_dly << 1) | DUT_LAT'(pat_valid);
                end
            end
            assign w_cap_en = r_dly[DUT_LAT-1];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_next = (n_patterns == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        w_next = (DUT_LAT > 0) ? DRAIN : DONE;
                    end
                end
                DRAIN: begin
                    if (r_drain == '0) begin
                        w_next = DONE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Pattern generator, pattern counter, drain timer and signature register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= '0;
            r_misr  <= '0;
            r_count <= '0;
            r_drain <= '0;
        end else if (abort) begin
            r_misr  <= '0;
        end else begin
            if (w_load) begin
                r_lfsr  <= (seed == '0) ? N_IN'(1) : seed;
                r_count <= n_patterns;
            end else if (r_state == RUN) begin
                r_lfsr  <= {r_lfsr[N_IN-2:0], w_lfsr_fb};
                r_count <= r_count - CNT_W'(1);
            end
            if (w_load) begin
                r_misr <= '0;
            end else if (w_cap_en) begin
                r_misr <= {r_misr[N_OUT-2:0], w_misr_fb} ^ resp_in;
            end
            if (r_state == RUN && w_last) begin
                r_drain <= DW'(DUT_LAT - 1);
            end else if (r_state == DRAIN) begin
                r_drain <= r_drain - DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bist_pattern_harness.sv
// Directed bench for bist_pattern_harness: one instance with a combinational DUT,
// one with a two-cycle DUT latency.
module tb_bist_pattern_harness;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start2, abort;
    logic [10:0] seed;
    logic [15:0] n;
    logic [22:0] golden;
    logic        loop;
    logic [22:0] rconst0, resp2;
    logic [22:0] resp0;

    logic [10:0] pat0, pat2;
    logic        pv0, pv2, busy0, busy2, done0, done2, pass0, pass2;
    logic [22:0] sig0, sig2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign resp0 = loop ? {12'b0, pat0} : rconst0;

    bist_pattern_harness #(.DUT_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .seed(seed), .n_patterns(n), .golden(golden),
        .pat_out(pat0), .pat_valid(pv0), .resp_in(resp0),
        .busy(busy0), .done(done0), .signature(sig0), .pass(pass0)
    );

    bist_pattern_harness #(.DUT_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
        .seed(seed), .n_patterns(n), .golden(golden),
        .pat_out(pat2), .pat_valid(pv2), .resp_in(resp2),
        .busy(busy2), .done(done2), .signature(sig2), .pass(pass2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start0 = 0; start2 = 0; abort = 0;
        seed = 11'd1; n = 16'd3; golden = '0; loop = 0;
        rconst0 = '0; resp2 = '0;
        #12;
        chk("rst_pat_out", 32'(pat0), 0);
        chk("rst_pat_valid", 32'(pv0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_sig", 32'(sig0), 0);
        chk("rst_pass", 32'(pass0), 0);
        rst_n = 1'b1;
        tick();

        // seed=1, n=3, zero responses
        start0 = 1; tick(); start0 = 0;
        chk("a_pv1", 32'(pv0), 1);
        chk("a_pat1", 32'(pat0), 32'h001);
        chk("a_busy", 32'(busy0), 1);
        tick();
        chk("a_pat2", 32'(pat0), 32'h002);
        tick();
        chk("a_pat3", 32'(pat0), 32'h004);
        chk("a_notdone", 32'(done0), 0);
        tick();
        chk("a_done", 32'(done0), 1);
        chk("a_pv_off", 32'(pv0), 0);
        chk("a_busy_off", 32'(busy0), 0);
        chk("a_sig", 32'(sig0), 0);
        chk("a_pass", 32'(pass0), 1);
        chk("a_pat_hold", 32'(pat0), 32'h008);

        // loopback n=1 and n=2
        loop = 1; n = 16'd1; golden = 23'h1;
        start0 = 1; tick(); start0 = 0;
        tick();
        chk("lb1_done", 32'(done0), 1);
        chk("lb1_sig", 32'(sig0), 32'h000001);
        chk("lb1_pass", 32'(pass0), 1);
        n = 16'd2;
        start0 = 1; tick(); start0 = 0;
        chk("lb2_restart", 32'(done0), 0);
        tick(); tick();
        chk("lb2_done", 32'(done0), 1);
        chk("lb2_sig", 32'(sig0), 32'h000000);
        chk("lb2_pass_bad", 32'(pass0), 0);
        loop = 0;

        // full period with seed 1 and seed 0
        for (int s = 0; s < 2; s++) begin
            seed = (s == 0) ? 11'd1 : 11'd0;
            n = 16'd2047;
            start0 = 1; tick(); start0 = 0;
            chk("per_first", 32'(pat0), 32'h001);
            repeat (2046) tick();
            chk("per_busy", 32'(busy0), 1);
            tick();
            chk("per_done", 32'(done0), 1);
            chk("per_final", 32'(pat0), 32'h001);
        end

        // abort in 5th RUN cycle; start while busy ignored
        seed = 11'd1; n = 16'd100; rconst0 = 23'h1;
        start0 = 1; tick(); start0 = 0;
        tick(); tick();
        seed = 11'd7; n = 16'd2; start0 = 1;
        tick(); start0 = 0;
        chk("ign_pat", 32'(pat0), 32'h008);
        tick();
        chk("ign_busy", 32'(busy0), 1);
        chk("ign_pat5", 32'(pat0), 32'h010);
        chk("pre_abort_sig", 32'(sig0), 32'h00000F);
        abort = 1; start0 = 1; tick(); abort = 0; start0 = 0;
        chk("ab_busy", 32'(busy0), 0);
        chk("ab_done", 32'(done0), 0);
        chk("ab_pv", 32'(pv0), 0);
        chk("ab_sig", 32'(sig0), 0);
        tick();
        chk("ab_idle", 32'(busy0 | done0), 0);
        rconst0 = '0;

        // n_patterns = 0
        n = 16'd0; golden = '0;
        start0 = 1; tick(); start0 = 0;
        chk("z_done", 32'(done0), 1);
        chk("z_pv", 32'(pv0), 0);
        chk("z_sig", 32'(sig0), 0);
        chk("z_pass", 32'(pass0), 1);
        golden = 23'h5;
        start0 = 1; tick(); start0 = 0;
        chk("z_done2", 32'(done0), 1);
        chk("z_fail", 32'(pass0), 0);

        // DUT_LAT=2, n=4, constant response 1
        seed = 11'd1; n = 16'd4; resp2 = 23'h1; golden = 23'h00000F;
        start2 = 1; tick(); start2 = 0;
        chk("l2_pv", 32'(pv2), 1);
        tick();
        chk("l2_sig_e1", 32'(sig2), 0);
        tick();
        chk("l2_sig_e2", 32'(sig2), 0);
        tick();
        chk("l2_sig_e3", 32'(sig2), 32'h1);
        tick();
        chk("l2_sig_e4", 32'(sig2), 32'h3);
        chk("l2_drain_pv", 32'(pv2), 0);
        chk("l2_drain_busy", 32'(busy2), 1);
        tick();
        chk("l2_sig_e5", 32'(sig2), 32'h7);
        chk("l2_notdone", 32'(done2), 0);
        tick();
        chk("l2_sig_e6", 32'(sig2), 32'hF);
        chk("l2_done", 32'(done2), 1);
        chk("l2_pass", 32'(pass2), 1);

        // async reset in the middle of DRAIN
        start2 = 1; tick(); start2 = 0;
        repeat (4) tick();
        chk("ar_in_drain", 32'(busy2 & ~pv2), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy2), 0);
        chk("ar_done", 32'(done2), 0);
        chk("ar_sig", 32'(sig2), 0);
        chk("ar_pat", 32'(pat2), 0);
        chk("ar_pv", 32'(pv2), 0);
        chk("ar_pass", 32'(pass2), 0);
        #3 rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
